remap_decode: RTL

Inverse of the ReMap encoder. It accepts a `NUM_LENGTH`-bit code word `{k, m2}`, undoes the mantissa remap, and re-expands the leading-one position to reconstruct the integer. It sits downstream of storage or transport of remapped values and returns them to linear integer form. It is a 3-stage valid/ready pipeline with bubble collapsing, so it sustains one word per cycle.

---
 rtl/remap_decode_pkg.sv | 18 +
 rtl/remap_decode_inv_remap.sv | 21 ++
 rtl/remap_decode.sv | 84 ++++++++
 3 files changed

// File: rtl/remap_decode_pkg.sv
// Shared widths and field layout of the ReMap code word {k, m2}.
package remap_decode_pkg;

  localparam int unsigned NUM_LENGTH  = 32;
  localparam int unsigned K_LENGTH    = 5;
  localparam int unsigned M2_LENGTH   = NUM_LENGTH - K_LENGTH;
  localparam int unsigned M1_LENGTH   = 31;
  localparam int unsigned K_MSB       = NUM_LENGTH - 1;
  localparam int unsigned M2_MSB      = M2_LENGTH - 1;
  // Linear mantissa bits the encoder discards below the m2 precision.
  localparam int unsigned DROP_LENGTH = M1_LENGTH - M2_LENGTH;

  typedef struct packed {
    logic [K_LENGTH-1:0]  k;
    logic [M2_LENGTH-1:0] m2;
  } code_t;

endpackage

// File: rtl/remap_decode_inv_remap.sv
// Inverse mantissa remap: m2 holds the Gray code of the top M2_LENGTH bits of m1,
// so a prefix XOR from the MSB recovers them; the dropped low bits return as zero.
module remap_decode_inv_remap
  import remap_decode_pkg::*;
(
  input  logic [M2_LENGTH-1:0] m2,
  output logic [M1_LENGTH-1:0] m1
);

  logic [M2_LENGTH-1:0] bin;

  always_comb begin
    bin         = '0;
    bin[M2_MSB] = m2[M2_MSB];
    for (int i = int'(M2_MSB) - 1; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ m2[i];
    end
    m1 = {bin, {DROP_LENGTH{1'b0}}};
  end

endmodule

// File: rtl/remap_decode.sv
// ReMap decoder: capture, unmap, expand; 3-stage valid/ready pipeline that
// collapses bubbles and sustains one word per cycle.
module remap_decode
  import remap_decode_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  code_valid_i,
  output logic                  code_ready_o,
  input  logic [NUM_LENGTH-1:0] code_i,
  output logic                  num_valid_o,
  input  logic                  num_ready_i,
  output logic [NUM_LENGTH-1:0] num_o,
  output logic                  err_o
);

  code_t code;
  assign code = code_i;

  logic v1_q, v2_q, v3_q;
  logic ready1, ready2, ready3;

  logic [K_LENGTH-1:0]   k1_q, k2_q;
  logic [M2_LENGTH-1:0]  m2_1_q;
  logic [M1_LENGTH-1:0]  m1_d, m1_2_q;
  logic                  err1_d, err1_q, err2_q, err3_q;
  logic [K_LENGTH-1:0]   shamt;
  logic [NUM_LENGTH-1:0] num_d, num_q;

  assign ready3       = !v3_q || num_ready_i;
  assign ready2       = !v2_q || ready3;
  assign ready1       = !v1_q || ready2;
  assign code_ready_o = ready1;

  assign err1_d = (code.k == '0) && (code.m2 != '0);

  remap_decode_inv_remap u_inv_remap (
    .m2 (m2_1_q),
    .m1 (m1_d)
  );

  // Leading one lands at bit k; mantissa bits pushed below bit 0 are already lost upstream.
  assign shamt = K_LENGTH'(M1_LENGTH) - k2_q;
  assign num_d = {1'b1, m1_2_q} >> shamt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      k1_q   <= '0;
      m2_1_q <= '0;
      err1_q <= 1'b0;
      k2_q   <= '0;
      m1_2_q <= '0;
      err2_q <= 1'b0;
      num_q  <= '0;
      err3_q <= 1'b0;
    end else begin
      if (ready1) v1_q <= code_valid_i;
      if (ready1 && code_valid_i) begin
        k1_q   <= code.k;
        m2_1_q <= code.m2;
        err1_q <= err1_d;
      end
      if (ready2) v2_q <= v1_q;
      if (ready2 && v1_q) begin
        k2_q   <= k1_q;
        m1_2_q <= m1_d;
        err2_q <= err1_q;
      end
      if (ready3) v3_q <= v2_q;
      if (ready3 && v2_q) begin
        num_q  <= num_d;
        err3_q <= err2_q;
      end
    end
  end

  assign num_valid_o = v3_q;
  assign num_o       = num_q;
  assign err_o       = err3_q;

endmodule
